// File: rtl/hyperbus_clk_seq.sv
// HyperBus clock-enable / chip-select sequencer: walks one transaction through
// CS setup, CA, latency, data, CS hold and CS recovery, enforcing tCSM.
module hyperbus_clk_seq #(
  parameter int CS_SETUP_CYCLES = 1,
  parameter int CS_HOLD_CYCLES  = 1,
  parameter int CS_HIGH_CYCLES  = 2,
  parameter int MAX_CS_CYCLES   = 512,
  parameter int LEN_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [3:0]       req_lat_i,
  input  logic             req_nolat_i,
  input  logic             lat_2x_i,
  input  logic             data_ready_i,
  input  logic             abort_i,
  output logic             clk_en_o,
  output logic             cs_no,
  output logic             ca_phase_o,
  output logic             data_phase_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CSW = $clog2(MAX_CS_CYCLES + 16);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CA,
    ST_LAT,
    ST_DATA,
    ST_CS_HOLD,
    ST_RECOVER
  } state_t;

  state_t             state_reg, state_next;
  logic [4:0]         cnt_reg, cnt_next;
  logic [LEN_W-1:0]   words_reg, words_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [3:0]         lat_reg, lat_next;
  logic               nolat_reg, nolat_next;
  logic               err_flag_reg, err_flag_next;
  logic [CSW-1:0]     cs_cnt_reg, cs_cnt_next;

  logic ready_reg, cs_n_reg, ca_reg, clk_run_reg, data_st_reg, done_reg, err_out_reg;

  logic       cs_active;
  logic       burst_state;
  logic       tcsm_expired;
  logic       kill;
  logic [4:0] eff_lat;

  assign cs_active    = state_reg inside {ST_CS_SETUP, ST_CA, ST_LAT, ST_DATA, ST_CS_HOLD};
  assign burst_state  = state_reg inside {ST_CA, ST_LAT, ST_DATA};
  // cs_cnt_next is the CS-low count including the current cycle
  assign cs_cnt_next  = cs_active ? cs_cnt_reg + 1'b1 : '0;
  assign tcsm_expired = burst_state && (cs_cnt_next >= CSW'(MAX_CS_CYCLES));
  assign kill         = tcsm_expired || (abort_i && (burst_state || state_reg == ST_CS_SETUP));
  assign eff_lat      = lat_2x_i ? {lat_reg, 1'b0} : {1'b0, lat_reg};

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    words_next    = words_reg;
    len_next      = len_reg;
    lat_next      = lat_reg;
    nolat_next    = nolat_reg;
    err_flag_next = err_flag_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_next    = ST_CS_SETUP;
          cnt_next      = 5'(CS_SETUP_CYCLES);
          len_next      = req_len_i;
          lat_next      = req_lat_i;
          nolat_next    = req_nolat_i;
          err_flag_next = 1'b0;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_reg == 5'd1) begin
          state_next = ST_CA;
          cnt_next   = 5'd3;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_CA: begin
        if (cnt_reg == 5'd1) begin
          if (!nolat_reg && eff_lat != 5'd0) begin
            state_next = ST_LAT;
            cnt_next   = eff_lat;
          end else if (len_reg == '0) begin
            state_next = ST_CS_HOLD;
            cnt_next   = 5'(CS_HOLD_CYCLES);
          end else begin
            state_next = ST_DATA;
            words_next = len_reg;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_LAT: begin
        if (cnt_reg == 5'd1) begin
          if (len_reg == '0) begin
            state_next = ST_CS_HOLD;
            cnt_next   = 5'(CS_HOLD_CYCLES);
          end else begin
            state_next = ST_DATA;
            words_next = len_reg;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_DATA: begin
        if (data_ready_i) begin
          words_next = words_reg - 1'b1;
          if (words_reg == LEN_W'(1)) begin
            state_next = ST_CS_HOLD;
            cnt_next   = 5'(CS_HOLD_CYCLES);
          end
        end
      end
      ST_CS_HOLD: begin
        if (cnt_reg == 5'd1) begin
          state_next = ST_RECOVER;
          cnt_next   = 5'(CS_HIGH_CYCLES);
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RECOVER: begin
        if (cnt_reg == 5'd1) begin
          state_next    = ST_IDLE;
          err_flag_next = 1'b0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort and tCSM expiry share one path so they raise a single error
    if (kill) begin
      state_next    = ST_CS_HOLD;
      cnt_next      = 5'(CS_HOLD_CYCLES);
      err_flag_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      words_reg    <= '0;
      len_reg      <= '0;
      lat_reg      <= '0;
      nolat_reg    <= 1'b0;
      err_flag_reg <= 1'b0;
      cs_cnt_reg   <= '0;
      ready_reg    <= 1'b1;
      cs_n_reg     <= 1'b1;
      ca_reg       <= 1'b0;
      clk_run_reg  <= 1'b0;
      data_st_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_out_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      words_reg    <= words_next;
      len_reg      <= len_next;
      lat_reg      <= lat_next;
      nolat_reg    <= nolat_next;
      err_flag_reg <= err_flag_next;
      cs_cnt_reg   <= cs_cnt_next;
      // Outputs are registered from the next state so they align with it
      ready_reg    <= (state_next == ST_IDLE);
      cs_n_reg     <= (state_next == ST_IDLE) || (state_next == ST_RECOVER);
      ca_reg       <= (state_next == ST_CA);
      clk_run_reg  <= (state_next == ST_CA) || (state_next == ST_LAT);
      data_st_reg  <= (state_next == ST_DATA);
      done_reg     <= (state_next == ST_RECOVER) && (cnt_next == 5'd1);
      err_out_reg  <= (state_next == ST_RECOVER) && (cnt_next == 5'd1) && err_flag_next;
    end
  end

  assign req_ready_o  = ready_reg;
  assign cs_no        = cs_n_reg;
  assign ca_phase_o   = ca_reg;
  assign data_phase_o = data_st_reg & data_ready_i;
  assign clk_en_o     = clk_run_reg | data_phase_o;
  assign done_o       = done_reg;
  assign err_o        = err_out_reg;

endmodule
